// File: rtl/wbu_fifo_arbiter.sv
// wbu_fifo_arbiter: packet-locked two-source round-robin arbiter driving a credit-tracked FIFO write port.
// Define WBUARB_PRIORITY_EN for fixed A-over-B priority in IDLE instead of round-robin.
module wbu_fifo_arbiter #(
  parameter int BW     = 36,
  parameter int LGFLEN = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_a_stb,
  input  logic [BW-1:0]     i_a_data,
  input  logic              i_a_last,
  output logic              o_a_busy,
  input  logic              i_b_stb,
  input  logic [BW-1:0]     i_b_data,
  input  logic              i_b_last,
  output logic              o_b_busy,
  output logic              o_fifo_wr,
  output logic [BW-1:0]     o_fifo_data,
  input  logic              i_fifo_rd,
  output logic [LGFLEN-1:0] o_fill,
  output logic              o_err
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  localparam logic [LGFLEN-1:0] CAP = {LGFLEN{1'b1}};
  state_t state_q, state_d;
  logic last_b_q, last_b_d;
  logic [LGFLEN-1:0] fill_q, fill_d;
  logic wr_q, err_q, err_d;
  logic [BW-1:0] data_q;
  logic room, sel_a, sel_b, acc_a, acc_b, acc, pop;
  always_comb begin
    room = fill_q != CAP;
`ifdef WBUARB_PRIORITY_EN
    sel_a = state_q == OWN_A || (state_q == IDLE && i_a_stb);
`else
    sel_a = state_q == OWN_A || (state_q == IDLE && i_a_stb && (!i_b_stb || last_b_q));
`endif
    sel_b = state_q == OWN_B || (state_q == IDLE && i_b_stb && !sel_a);
    acc_a = !i_rst && i_a_stb && sel_a && room;
    acc_b = !i_rst && i_b_stb && sel_b && room;
    acc = acc_a || acc_b;
    // a pop with no credits is an error, never an underflow
    pop = i_fifo_rd && fill_q != '0;
    fill_d = (acc && !pop) ? fill_q + 1'b1 : (!acc && pop) ? fill_q - 1'b1 : fill_q;
    err_d = i_fifo_rd && fill_q == '0 && !acc;
    state_d = state_q;
    last_b_d = last_b_q;
    if (acc_a) begin
      state_d = i_a_last ? IDLE : OWN_A;
      last_b_d = i_a_last ? 1'b0 : last_b_q;
    end
    if (acc_b) begin
      state_d = i_b_last ? IDLE : OWN_B;
      last_b_d = i_b_last ? 1'b1 : last_b_q;
    end
  end
  assign o_a_busy = i_rst || !(sel_a && room);
  assign o_b_busy = i_rst || !(sel_b && room);
  assign o_fifo_wr = wr_q;
  assign o_fifo_data = data_q;
  assign o_fill = fill_q;
  assign o_err = err_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      last_b_q <= 1'b1;
      fill_q <= '0;
      wr_q <= 1'b0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_b_q <= last_b_d;
      fill_q <= fill_d;
      wr_q <= acc;
      if (acc) data_q <= acc_a ? i_a_data : i_b_data;
      err_q <= err_d;
    end
  end
endmodule
